regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 62 ++++++
 tb/tb_regfile_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: DEPTH x DATA_W register file with a background clear FSM.
// Define REGFILE_BYPASS_EN to forward an accepted write to rd1/rd2 in the same cycle.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              clr_req,
   output logic              busy,
   output logic              wr_drop
);
   typedef enum logic {IDLE, CLEAR} state_t;
   localparam logic [ADDR_W:0]   DEPTH_V = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
   logic [DATA_W-1:0] mem [DEPTH];
   state_t            state;
   logic [ADDR_W-1:0] clr_ptr;
   logic              wr_ok;
   // Same rule gates both writes and reads: in range and not the hardwired zero register.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_V) && !(ZERO_REG != 0 && a == '0);
   endfunction
   assign busy  = (state == CLEAR);
   assign wr_ok = rst && we && !busy && addr_ok(wa);
   always_comb begin
      rd1 = addr_ok(ra1) ? mem[ra1] : '0;
      rd2 = addr_ok(ra2) ? mem[ra2] : '0;
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && ra1 == wa) rd1 = wd;
      if (wr_ok && ra2 == wa) rd2 = wd;
`endif
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         state   <= IDLE;
         clr_ptr <= '0;
         wr_drop <= 1'b0;
      end else begin
         wr_drop <= we && !wr_ok;
         if (wr_ok) mem[wa] <= wd;
         if (busy) begin
            mem[clr_ptr] <= '0;
            clr_ptr      <= clr_ptr + 1'b1;
            state        <= (clr_ptr == LAST) ? IDLE : CLEAR;
         end else if (clr_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
         end
      end
   end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: drives a DEPTH=32 and a DEPTH=24 instance with shared stimulus
// and checks both against a behavioural model every cycle plus directed expectations.
module tb_regfile_param;
   logic        clk = 0, rst = 0, we = 0, clr_req = 0;
   logic [4:0]  wa = 0, ra1 = 0, ra2 = 0;
   logic [31:0] wd = 0;
   logic [31:0] rd1_o [2];
   logic [31:0] rd2_o [2];
   logic        busy_o [2];
   logic        drop_o [2];
   int          checks = 0, errors = 0;
   bit          chk_on = 0;
   logic [31:0] m [2][32];
   int          dep [2] = '{32, 24};
   int          clr_left [2] = '{0, 0};
   logic        exp_drop [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   regfile_param u_dut32 (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
      .rd1(rd1_o[0]), .rd2(rd2_o[0]), .clr_req(clr_req), .busy(busy_o[0]), .wr_drop(drop_o[0])
   );
   regfile_param #(.DEPTH(24)) u_dut24 (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
      .rd1(rd1_o[1]), .rd2(rd2_o[1]), .clr_req(clr_req), .busy(busy_o[1]), .wr_drop(drop_o[1])
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic bit acc_now(input int k);
      return rst && we && clr_left[k] == 0 && int'(wa) < dep[k] && wa != 0;
   endfunction

   function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a);
      if (a == 0 || int'(a) >= dep[k]) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (acc_now(k) && a == wa) return wd;
`endif
      return m[k][a];
   endfunction

   // Model: a clear lasts dep cycles and zeroes register (dep - cycles_left) each cycle.
   always @(posedge clk) begin
      bit acc;
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            for (int i = 0; i < 32; i++) m[k][i] = 32'h0;
            clr_left[k] = 0;
            exp_drop[k] = 1'b0;
         end else begin
            acc = acc_now(k);
            exp_drop[k] = we && !acc;
            if (clr_left[k] > 0) begin
               m[k][dep[k] - clr_left[k]] = 32'h0;
               clr_left[k]--;
            end else if (clr_req) clr_left[k] = dep[k];
            if (acc) m[k][wa] = wd;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("model rd1 d%0d a=%0d", dep[k], ra1), rd1_o[k], exp_rd(k, ra1));
            check($sformatf("model rd2 d%0d a=%0d", dep[k], ra2), rd2_o[k], exp_rd(k, ra2));
            check($sformatf("model busy d%0d", dep[k]), 32'(busy_o[k]), 32'(clr_left[k] > 0));
            check($sformatf("model wr_drop d%0d", dep[k]), 32'(drop_o[k]), 32'(exp_drop[k]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sweep();
      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a);
         ra2 = 5'(31 - a);
         tick();
      end
   endtask

   initial begin
      int n, drops32, drops24;
      repeat (2) @(posedge clk);
      #1 rst = 1; ra1 = 0; ra2 = 1; chk_on = 1;
      #1 check("reset rd1", rd1_o[0], 32'h0);
      check("reset rd2", rd2_o[0], 32'h0);
      check("reset busy", 32'(busy_o[0]), 32'h0);
      check("reset wr_drop", 32'(drop_o[0]), 32'h0);
      drops32 = 0;
      drops24 = 0;
      for (int i = 0; i < 32; i++) begin
         we = 1; wa = 5'(i); wd = 32'(i * 'h11);
         tick();
         drops32 += int'(drop_o[0]);
         drops24 += int'(drop_o[1]);
      end
      we = 0;
      check("fill drops d32", 32'(drops32), 32'd1);
      check("fill drops d24", 32'(drops24), 32'd9);
      ra1 = 0; ra2 = 1;
      #1 check("r0", rd1_o[0], 32'h0);
      check("r1", rd2_o[0], 32'h11);
      ra1 = 2; ra2 = 31;
      #1 check("r2", rd1_o[0], 32'h22);
      check("r31", rd2_o[0], 32'h20F);
      check("d24 r31", rd2_o[1], 32'h0);
      we = 1; wa = 5; wd = 32'hDEADBEEF; ra1 = 5;
`ifdef REGFILE_BYPASS_EN
      #1 check("r5 before edge fwd", rd1_o[0], 32'hDEADBEEF);
`else
      #1 check("r5 before edge", rd1_o[0], 32'h55);
`endif
      tick();
      we = 0;
      #1 check("r5 after edge", rd1_o[0], 32'hDEADBEEF);
      we = 1; wa = 30; wd = 32'hAA; ra1 = 30;
      #1 check("d24 wa30 not fwd", rd1_o[1], 32'h0);
      tick();
      we = 0;
      #1 check("d24 wa30 drop", 32'(drop_o[1]), 32'h1);
      check("d32 wa30 no drop", 32'(drop_o[0]), 32'h0);
      check("d24 ra30", rd1_o[1], 32'h0);
      check("d32 r30", rd1_o[0], 32'hAA);
      tick();
      check("d24 drop one cycle", 32'(drop_o[1]), 32'h0);
      ra1 = 23; ra2 = 5;
      #1 check("d24 r23", rd1_o[1], 32'h187);
      check("d24 r5", rd2_o[1], 32'hDEADBEEF);
      sweep();
      clr_req = 1;
      tick();
      clr_req = 0;
      n = 0;
      while (busy_o[0] && n < 100) begin
         we = (n == 3); wa = 3; wd = 32'h1234;
         tick();
         n++;
         we = 0;
         if (n == 4) check("drop during busy", 32'(drop_o[0]), 32'h1);
         if (n == 23) check("d24 busy at 23", 32'(busy_o[1]), 32'h1);
         if (n == 24) check("d24 busy at 24", 32'(busy_o[1]), 32'h0);
      end
      check("busy cycles", 32'(n), 32'd32);
      sweep();
      ra1 = 3; ra2 = 31;
      #1 check("r3 cleared", rd1_o[0], 32'h0);
      check("r31 cleared", rd2_o[0], 32'h0);
      we = 1; wa = 20; wd = 32'h99;
      tick();
      we = 0;
      clr_req = 1;
      tick();
      clr_req = 0;
      repeat (10) tick();
      rst = 0;
      tick();
      check("busy after abort d32", 32'(busy_o[0]), 32'h0);
      check("busy after abort d24", 32'(busy_o[1]), 32'h0);
      rst = 1; ra1 = 20;
      #1 check("r20 reset", rd1_o[0], 32'h0);
      sweep();
      clr_req = 1;
      tick();
      clr_req = 0;
      check("new clear accepted", 32'(busy_o[0]), 32'h1);
      n = 0;
      while (busy_o[0] && n < 100) begin
         tick();
         n++;
      end
      check("second clear cycles", 32'(n), 32'd32);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
